alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 5: operand and result width, legal range 2..32.
REQ-002 Parameter SHAMT, default 2: fixed left-shift amount for opcode 0111, legal range 0..WIDTH-1.
REQ-003 Parameter DEFVAL, default 6: result driven for unlisted opcodes, truncated to WIDTH bits.
REQ-004 clk  input  1  single clock, all flops rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operation request valid.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 S  input  4  opcode, sampled at accept.
REQ-009 A  input  WIDTH  operand A, sampled at accept.
REQ-010 B  input  WIDTH  operand B, sampled at accept.
REQ-011 out_valid  output  1  Alu/flags hold a result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 Alu  output  WIDTH  registered result.
REQ-014 zero  output  1  registered, high when Alu == 0.
REQ-015 illegal  output  1  registered, high when the accepted opcode was unlisted.

Function
REQ-016 Accept occurs on a rising edge with in_valid && in_ready; S, A and B are captured only on accept.
REQ-017 FSM states: IDLE (no result), CALC (multiply in progress), DONE (out_valid=1).
REQ-018 in_ready = (state==IDLE) || (state==DONE && out_ready); in_ready is 0 in CALC.
REQ-019 Single-cycle opcodes (all except 1000) go to DONE; the result is visible on the edge after accept, for a latency of 1 cycle.
REQ-020 1101: Alu = ~(A & B), bitwise.
REQ-021 1100: Alu = A ^ B.
REQ-022 0111: Alu = A << SHAMT, zero-fill, truncated to WIDTH.
REQ-023 0101: Alu = {B[WIDTH-2:0], B[WIDTH-1]} (rotate B left by 1).
REQ-024 0001: Alu = max(A,B), unsigned; equal operands give A.
REQ-025 0000: Alu = all ones if A > B (unsigned), else all zeros.
REQ-026 1000: Alu = low WIDTH bits of A*B (unsigned), computed by shift-add in exactly WIDTH cycles in CALC, then DONE; accept-to-out_valid latency is WIDTH+1 cycles.
REQ-027 Any other opcode: Alu = DEFVAL, illegal = 1; otherwise illegal = 0.
REQ-028 zero is computed from the final Alu value and is updated together with Alu.
REQ-029 In DONE with out_ready=0: Alu, zero, illegal and out_valid hold stable; no new accept occurs.
REQ-030 In DONE with out_ready=1 and no accept: next state is IDLE and out_valid falls.
REQ-031 In DONE with out_ready=1 and an accept: back-to-back operation, so there is no bubble for single-cycle opcodes.
REQ-032 A 1000 opcode accepted from DONE drops out_valid during CALC.
REQ-033 Input changes during CALC or DONE have no effect on the result.
REQ-034 Multiply cycle counter: exactly ceil(log2(WIDTH+1)) bits, clears at each accept.

Reset
REQ-035 While rst=1 at a clock edge: state=IDLE, out_valid=0, Alu=0, zero=1, illegal=0, counter=0, and in_ready=1 from the next cycle.
REQ-036 rst has priority over accept and any in-progress multiply; a partial product is discarded, and no result is emitted for the aborted operation.

Verification
REQ-037 WIDTH=5, out_ready=1: accept S=1100 with A=5'h0F and B=5'h15 -> after 1 cycle out_valid=1, Alu=5'h1A, zero=0, illegal=0.
REQ-038 WIDTH=5: S=0000 with A=3, B=3 -> Alu=0, zero=1; S=0001 with A=3, B=9 -> Alu=9; S=0101 with B=5'b10011 -> Alu=5'b00111; S=0111 with A=5'b01011 -> Alu=5'b01100.
REQ-039 WIDTH=5: S=1000 with A=6, B=7 -> in_ready=0 for 5 cycles, out_valid on cycle 6, Alu=5'h0A (42 mod 32).
REQ-040 Backpressure: hold out_ready=0 for 4 cycles after a result -> Alu stable and in_ready=0 throughout; on release, a same-cycle new accept gives the next result on the following cycle.
REQ-041 S=1010 -> Alu=5'h06, illegal=1.
REQ-042 Assert rst on the 3rd cycle of a multiply -> next cycle state IDLE, out_valid=0, Alu=0, and no result emitted afterward without a new accept.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU (clk, rst, in_valid/in_ready, S/A/B in; out_valid/out_ready, Alu/zero/illegal out) with shift-add multiply
module alu_seq #(
  parameter int WIDTH  = 5,
  parameter int SHAMT  = 2,
  parameter int DEFVAL = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Alu,
  output logic             zero,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] alu_q, alu_d, mc_q, mc_d, mp_q, mp_d, acc_q, acc_d, res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic zero_q, zero_d, ill_q, ill_d, res_ill, accept, last;
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    in_ready = state_q == IDLE || (state_q == DONE && out_ready);
    out_valid = state_q == DONE;
    accept = in_valid && in_ready;
    last = state_q == CALC && cnt_q == CW'(WIDTH - 1);
  end
  always_comb begin
    state_d = state_q;
    if (accept) state_d = S == 4'b1000 ? CALC : DONE;
    else if (last) state_d = DONE;
    else if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_comb begin
    res = WIDTH'(DEFVAL);
    res_ill = 1'b0;
    case (S)
      4'b1101: res = ~(A & B);
      4'b1100: res = A ^ B;
      4'b0111: res = A << SHAMT;
      4'b0101: res = {B[WIDTH-2:0], B[WIDTH-1]};
      4'b0001: res = A >= B ? A : B;
      4'b0000: res = A > B ? '1 : '0;
      4'b1000: res = '0;
      default: res_ill = 1'b1;
    endcase
  end
  // multiplier walks B from the LSB while A shifts up; high bits drop out mod 2^WIDTH
  always_comb begin
    alu_d = alu_q;
    zero_d = zero_q;
    ill_d = ill_q;
    mc_d = mc_q;
    mp_d = mp_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
      mc_d = A;
      mp_d = B;
      acc_d = '0;
      if (S != 4'b1000) begin
        alu_d = res;
        zero_d = res == '0;
        ill_d = res_ill;
      end
    end else if (state_q == CALC) begin
      acc_d = mp_q[0] ? acc_q + mc_q : acc_q;
      mc_d = mc_q << 1;
      mp_d = mp_q >> 1;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        alu_d = acc_d;
        zero_d = acc_d == '0;
        ill_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q <= '0;
      zero_q <= 1'b1;
      ill_q <= 1'b0;
      mc_q <= '0;
      mp_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      alu_q <= alu_d;
      zero_q <= zero_d;
      ill_q <= ill_d;
      mc_q <= mc_d;
      mp_q <= mp_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  assign Alu = alu_q;
  assign zero = zero_q;
  assign illegal = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against a behavioural model
module tb_alu_seq;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, zero, illegal;
  logic [3:0] S = 0;
  logic [4:0] A = 0, B = 0, Alu;
  int total = 0, bad = 0;
  alu_seq dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .S(S), .A(A), .B(B),
               .out_valid(out_valid), .out_ready(out_ready), .Alu(Alu), .zero(zero), .illegal(illegal));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [5:0] model(input logic [3:0] s, input logic [4:0] a, input logic [4:0] b);
    int r;
    logic il;
    r = 0;
    il = 0;
    case (s)
      4'hD: r = 31 - int'(a & b);
      4'hC: r = int'(a ^ b);
      4'h7: r = (int'(a) * 4) % 32;
      4'h5: r = (int'(b) * 2 + int'(b) / 16) % 32;
      4'h1: r = (a >= b) ? int'(a) : int'(b);
      4'h0: r = (a > b) ? 31 : 0;
      4'h8: r = (int'(a) * int'(b)) % 32;
      default: begin r = 6; il = 1; end
    endcase
    return {il, 5'(r)};
  endfunction
  task automatic run_op(input logic [3:0] s, input logic [4:0] a, input logic [4:0] b,
                        output logic [4:0] alu, output logic z, output logic il, output int lat);
    S = s; A = a; B = b; in_valid = 1; out_ready = 1;
    step;
    in_valid = 0; S = 4'($urandom); A = 5'($urandom); B = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin step; lat++; end
    alu = Alu; z = zero; il = illegal;
  endtask
  task automatic test_reset;
    rst = 1;
    step; step;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (Alu !== 5'h00) begin bad++; $display("FAIL rst_alu got=%h exp=00", Alu); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b exp=1", zero); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%b exp=0", illegal); end
    rst = 0;
    step;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
  endtask
  task automatic test_directed;
    int ds[7] = '{12, 0, 1, 5, 7, 8, 10};
    int da[7] = '{5'h0F, 3, 3, 0, 5'b01011, 6, 1};
    int db[7] = '{5'h15, 3, 9, 5'b10011, 0, 7, 2};
    int de[7] = '{5'h1A, 0, 9, 5'b00111, 5'b01100, 5'h0A, 6};
    int di[7] = '{0, 0, 0, 0, 0, 0, 1};
    int dl[7] = '{1, 1, 1, 1, 1, 6, 1};
    logic [4:0] alu;
    logic z, il;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(4'(ds[i]), 5'(da[i]), 5'(db[i]), alu, z, il, lat);
      total++; if (alu !== 5'(de[i])) begin bad++; $display("FAIL dir_alu[%0d] got=%h exp=%h", i, alu, 5'(de[i])); end
      total++; if (z !== (de[i] == 0)) begin bad++; $display("FAIL dir_zero[%0d] got=%b exp=%b", i, z, de[i] == 0); end
      total++; if (il !== 1'(di[i])) begin bad++; $display("FAIL dir_illegal[%0d] got=%b exp=%0d", i, il, di[i]); end
      total++; if (lat != dl[i]) begin bad++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, dl[i]); end
    end
  endtask
  task automatic test_random;
    logic [3:0] s;
    logic [4:0] a, b, alu;
    logic [5:0] e;
    logic z, il;
    int lat;
    for (int i = 0; i < 80; i++) begin
      s = 4'($urandom); a = 5'($urandom); b = 5'($urandom);
      if (i % 4 == 0) b = a;
      e = model(s, a, b);
      run_op(s, a, b, alu, z, il, lat);
      total++; if (alu !== e[4:0]) begin bad++; $display("FAIL rnd_alu s=%h a=%h b=%h got=%h exp=%h", s, a, b, alu, e[4:0]); end
      total++; if (il !== e[5]) begin bad++; $display("FAIL rnd_illegal s=%h got=%b exp=%b", s, il, e[5]); end
      total++; if (z !== (e[4:0] == 0)) begin bad++; $display("FAIL rnd_zero s=%h got=%b exp=%b", s, z, e[4:0] == 0); end
      total++; if (lat != (s == 4'h8 ? 6 : 1)) begin bad++; $display("FAIL rnd_latency s=%h got=%0d exp=%0d", s, lat, s == 4'h8 ? 6 : 1); end
      if (i % 3 == 0) step;
    end
  endtask
  task automatic test_mul;
    logic [4:0] alu;
    logic z, il;
    int lat;
    run_op(4'hC, 5'h01, 5'h02, alu, z, il, lat);
    S = 4'h8; A = 5'd6; B = 5'd7; in_valid = 1;
    step;
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mul_ready[%0d] got=%b exp=0", i, in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mul_valid[%0d] got=%b exp=0", i, out_valid); end
      A = 5'($urandom); B = 5'($urandom); S = 4'($urandom); in_valid = 1;
      step;
      in_valid = 0;
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mul_done got=%b exp=1", out_valid); end
    total++; if (Alu !== 5'h0A) begin bad++; $display("FAIL mul_alu got=%h exp=0a", Alu); end
    step;
  endtask
  task automatic test_backpressure;
    logic [4:0] alu, e;
    logic z, il;
    int lat;
    run_op(4'hC, 5'h0F, 5'h15, alu, z, il, lat);
    out_ready = 0;
    S = 4'hD; A = 5'h03; B = 5'h05; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      step;
      total++; if (Alu !== 5'h1A) begin bad++; $display("FAIL bp_alu[%0d] got=%h exp=1a", i, Alu); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
    end
    out_ready = 1;
    e = model(4'hD, 5'h03, 5'h05);
    step;
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%b exp=1", out_valid); end
    total++; if (Alu !== e) begin bad++; $display("FAIL bp_next_alu got=%h exp=%h", Alu, e); end
  endtask
  task automatic test_back_to_back;
    logic [3:0] s;
    logic [4:0] a, b, alu;
    logic [5:0] e;
    logic z, il;
    int lat;
    for (int i = 0; i < 6; i++) begin
      s = (i % 2 == 0) ? 4'hC : 4'h1; a = 5'($urandom); b = 5'($urandom);
      e = model(s, a, b);
      run_op(s, a, b, alu, z, il, lat);
      total++; if (lat != 1) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=1", i, lat); end
      total++; if (alu !== e[4:0]) begin bad++; $display("FAIL b2b_alu[%0d] got=%h exp=%h", i, alu, e[4:0]); end
    end
  endtask
  task automatic test_reset_mid_mul;
    logic [4:0] alu;
    logic z, il;
    int lat;
    int seen;
    run_op(4'hC, 5'h0F, 5'h15, alu, z, il, lat);
    S = 4'h8; A = 5'd13; B = 5'd11; in_valid = 1;
    step;
    in_valid = 0;
    step; step;
    rst = 1;
    step;
    rst = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", out_valid); end
    total++; if (Alu !== 5'h00) begin bad++; $display("FAIL abort_alu got=%h exp=00", Alu); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", in_ready); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step;
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_no_result got=%0d exp=0", seen); end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_random;
    test_mul;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_mul;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
